lease_arbiter: RTL and testbench



---
 rtl/lease_arbiter.sv | 162 ++++++++++++++++
 tb/tb_lease_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lease_arbiter.sv
// lease_arbiter
//   Shares one resource among four requesters in strict arrival order.
//   A requester keeps the resource while its request stays high and releases
//   it by dropping the request. Queued requesters may withdraw at any time.
//   An optional hold watchdog revokes grants that last MAX_HOLD cycles, and a
//   one-cycle GAP state separates consecutive owners.
//
// Parameters:
//   MAX_HOLD     cycles a grant may be held before revocation (0 = no watchdog)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   req[3:0]     request lines; req[i] high = requester i wants/holds resource
//   grant[3:0]   one-hot grant or zero, registered
//   grant_id     index of the current owner, 0 when idle
//   busy         high while any grant is asserted
//   revoke       one-cycle pulse when the watchdog withdraws a grant
//   queue_count  number of requesters waiting (0..4)
module lease_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       revoke,
    output logic [2:0] queue_count
);

    localparam int unsigned CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [1:0]      q_id   [4];
    logic [1:0]      q_id_n [4];
    logic [1:0]      kept_id[4];
    logic [2:0]      kept_cnt;
    logic [2:0]      cnt_n;
    logic [3:0]      req_q;
    logic [3:0]      arriving;
    logic [CW-1:0]   hold_cnt, hold_cnt_n;
    logic [3:0]      grant_n;
    logic [1:0]      grant_id_n;
    logic            busy_n, revoke_n, pop;

    assign arriving = req & ~req_q;

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        grant_id_n = grant_id;
        busy_n     = busy;
        revoke_n   = 1'b0;
        hold_cnt_n = hold_cnt;
        pop        = 1'b0;
        kept_cnt   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            kept_id[i] = '0;
            q_id_n[i]  = '0;
        end

        // Withdrawals: keep only entries whose request is still high, in order.
        // A queued entry is never the owner, so no owner check is needed here.
        for (int unsigned i = 0; i < 4; i++) begin
            if (3'(i) < queue_count && req[q_id[i]]) begin
                kept_id[kept_cnt[1:0]] = q_id[i];
                kept_cnt = kept_cnt + 3'd1;
            end
        end

        case (state)
            IDLE: begin
                if (kept_cnt != 3'd0) begin
                    pop        = 1'b1;
                    grant_n    = 4'b0001 << kept_id[0];
                    grant_id_n = kept_id[0];
                    busy_n     = 1'b1;
                    hold_cnt_n = CW'(1);
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (!req[grant_id]) begin
                    grant_n    = '0;
                    grant_id_n = '0;
                    busy_n     = 1'b0;
                    state_n    = GAP;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT) begin
                    grant_n    = '0;
                    grant_id_n = '0;
                    busy_n     = 1'b0;
                    revoke_n   = 1'b1;
                    state_n    = GAP;
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + CW'(1);
                end
            end
            GAP: begin
                hold_cnt_n = '0;
                state_n    = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Pop happens on the compacted queue; arrivals are appended afterwards
        // so a requester arriving on this edge can never be popped on it.
        for (int unsigned j = 0; j < 3; j++) begin
            q_id_n[j] = pop ? kept_id[j + 1] : kept_id[j];
        end
        q_id_n[3] = pop ? 2'd0 : kept_id[3];
        cnt_n     = kept_cnt - {2'b00, pop};

        // Lowest index first for simultaneous arrivals. At most four distinct
        // requesters exist and the owner is never queued, so cnt_n stays <= 4.
        for (int unsigned j = 0; j < 4; j++) begin
            if (arriving[j]) begin
                q_id_n[cnt_n[1:0]] = 2'(j);
                cnt_n = cnt_n + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            revoke      <= 1'b0;
            queue_count <= '0;
            hold_cnt    <= '0;
            req_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                q_id[i] <= '0;
            end
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            busy        <= busy_n;
            revoke      <= revoke_n;
            queue_count <= cnt_n;
            hold_cnt    <= hold_cnt_n;
            req_q       <= req;
            for (int unsigned i = 0; i < 4; i++) begin
                q_id[i] <= q_id_n[i];
            end
        end
    end

endmodule

// File: tb/tb_lease_arbiter.sv
// tb_lease_arbiter
//   Directed bench for lease_arbiter with MAX_HOLD=4. Each task applies a
//   table of req vectors, one per clock edge, and compares the packed outputs
//   {grant, grant_id, busy, revoke, queue_count} after each edge against
//   hand-computed values.
module tb_lease_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       revoke;
    logic [2:0] queue_count;

    int checks = 0;
    int errors = 0;

    lease_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .revoke      (revoke),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] pk(input logic [3:0] g, input int id,
                                       input logic b, input logic r, input int qc);
        return {g, 2'(id), b, r, 3'(qc)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        obs = {grant, grant_id, busy, revoke, queue_count};
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, 11'd0);
        end
        rst = 1'b0;
        step();
        obs = {grant, grant_id, busy, revoke, queue_count};
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", obs, 11'd0);
        end
    endtask

    task automatic test_single();
        logic [3:0]  rv [5];
        logic [10:0] ev [5];
        logic [10:0] obs;
        rv = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        ev = '{pk(4'b0000,0,0,0,1), pk(4'b0001,0,1,0,0), pk(4'b0000,0,0,0,0),
               pk(4'b0000,0,0,0,0), pk(4'b0000,0,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            req = rv[i];
            step();
            obs = {grant, grant_id, busy, revoke, queue_count};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL single[%0d]: got g=%b id=%0d b=%b r=%b qc=%0d expected g=%b id=%0d b=%b r=%b qc=%0d",
                         i, grant, grant_id, busy, revoke, queue_count,
                         ev[i][10:7], ev[i][6:5], ev[i][4], ev[i][3], ev[i][2:0]);
            end
        end
    endtask

    task automatic test_order();
        logic [3:0]  rv [12];
        logic [10:0] ev [12];
        logic [10:0] obs;
        rv = '{4'b0100, 4'b0100, 4'b0101, 4'b1101, 4'b1001, 4'b1001,
               4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        ev = '{pk(4'b0000,0,0,0,1), pk(4'b0100,2,1,0,0), pk(4'b0100,2,1,0,1),
               pk(4'b0100,2,1,0,2), pk(4'b0000,0,0,0,2), pk(4'b0000,0,0,0,2),
               pk(4'b0001,0,1,0,1), pk(4'b0000,0,0,0,1), pk(4'b0000,0,0,0,1),
               pk(4'b1000,3,1,0,0), pk(4'b0000,0,0,0,0), pk(4'b0000,0,0,0,0)};
        for (int i = 0; i < 12; i++) begin
            req = rv[i];
            step();
            obs = {grant, grant_id, busy, revoke, queue_count};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL order[%0d]: got g=%b id=%0d b=%b r=%b qc=%0d expected g=%b id=%0d b=%b r=%b qc=%0d",
                         i, grant, grant_id, busy, revoke, queue_count,
                         ev[i][10:7], ev[i][6:5], ev[i][4], ev[i][3], ev[i][2:0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0]  rv [13];
        logic [10:0] ev [13];
        logic [10:0] obs;
        rv = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1100,
               4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        ev = '{pk(4'b0000,0,0,0,4), pk(4'b0001,0,1,0,3), pk(4'b0000,0,0,0,3),
               pk(4'b0000,0,0,0,3), pk(4'b0010,1,1,0,2), pk(4'b0000,0,0,0,2),
               pk(4'b0000,0,0,0,2), pk(4'b0100,2,1,0,1), pk(4'b0000,0,0,0,1),
               pk(4'b0000,0,0,0,1), pk(4'b1000,3,1,0,0), pk(4'b0000,0,0,0,0),
               pk(4'b0000,0,0,0,0)};
        for (int i = 0; i < 13; i++) begin
            req = rv[i];
            step();
            obs = {grant, grant_id, busy, revoke, queue_count};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL simultaneous[%0d]: got g=%b id=%0d b=%b r=%b qc=%0d expected g=%b id=%0d b=%b r=%b qc=%0d",
                         i, grant, grant_id, busy, revoke, queue_count,
                         ev[i][10:7], ev[i][6:5], ev[i][4], ev[i][3], ev[i][2:0]);
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0]  rv [12];
        logic [10:0] ev [12];
        logic [10:0] obs;
        rv = '{4'b0001, 4'b0001, 4'b1111, 4'b1011, 4'b1010, 4'b1010,
               4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
        ev = '{pk(4'b0000,0,0,0,1), pk(4'b0001,0,1,0,0), pk(4'b0001,0,1,0,3),
               pk(4'b0001,0,1,0,2), pk(4'b0000,0,0,0,2), pk(4'b0000,0,0,0,2),
               pk(4'b0010,1,1,0,1), pk(4'b0000,0,0,0,1), pk(4'b0000,0,0,0,1),
               pk(4'b1000,3,1,0,0), pk(4'b0000,0,0,0,0), pk(4'b0000,0,0,0,0)};
        for (int i = 0; i < 12; i++) begin
            req = rv[i];
            step();
            obs = {grant, grant_id, busy, revoke, queue_count};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL withdraw[%0d]: got g=%b id=%0d b=%b r=%b qc=%0d expected g=%b id=%0d b=%b r=%b qc=%0d",
                         i, grant, grant_id, busy, revoke, queue_count,
                         ev[i][10:7], ev[i][6:5], ev[i][4], ev[i][3], ev[i][2:0]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [3:0]  rv [16];
        logic [10:0] ev [16];
        logic [10:0] obs;
        rv = '{4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
               4'b1010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010,
               4'b0000, 4'b0000};
        ev = '{pk(4'b0000,0,0,0,1), pk(4'b0010,1,1,0,0), pk(4'b0010,1,1,0,1),
               pk(4'b0010,1,1,0,1), pk(4'b0010,1,1,0,1), pk(4'b0000,0,0,1,1),
               pk(4'b0000,0,0,0,1), pk(4'b1000,3,1,0,0), pk(4'b0000,0,0,0,0),
               pk(4'b0000,0,0,0,0), pk(4'b0000,0,0,0,0), pk(4'b0000,0,0,0,0),
               pk(4'b0000,0,0,0,1), pk(4'b0010,1,1,0,0), pk(4'b0000,0,0,0,0),
               pk(4'b0000,0,0,0,0)};
        for (int i = 0; i < 16; i++) begin
            req = rv[i];
            step();
            obs = {grant, grant_id, busy, revoke, queue_count};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL timeout[%0d]: got g=%b id=%0d b=%b r=%b qc=%0d expected g=%b id=%0d b=%b r=%b qc=%0d",
                         i, grant, grant_id, busy, revoke, queue_count,
                         ev[i][10:7], ev[i][6:5], ev[i][4], ev[i][3], ev[i][2:0]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0]  rv [7];
        logic [10:0] ev [7];
        logic [10:0] obs;
        rv = '{4'b0100, 4'b0100, 4'b0111, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        ev = '{pk(4'b0000,0,0,0,1), pk(4'b0100,2,1,0,0), pk(4'b0100,2,1,0,2),
               pk(4'b0000,0,0,0,1), pk(4'b0100,2,1,0,0), pk(4'b0000,0,0,0,0),
               pk(4'b0000,0,0,0,0)};
        for (int i = 0; i < 7; i++) begin
            req = rv[i];
            if (i == 3) begin
                // Pulse reset between edges, after req has dropped to 0100.
                #2;
                rst = 1'b1;
                #1;
                obs = {grant, grant_id, busy, revoke, queue_count};
                checks++;
                if (obs !== 11'd0) begin
                    errors++;
                    $display("FAIL reset_async: got %b expected %b", obs, 11'd0);
                end
                rst = 1'b0;
            end
            step();
            obs = {grant, grant_id, busy, revoke, queue_count};
            checks++;
            if (obs !== ev[i]) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got g=%b id=%0d b=%b r=%b qc=%0d expected g=%b id=%0d b=%b r=%b qc=%0d",
                         i, grant, grant_id, busy, revoke, queue_count,
                         ev[i][10:7], ev[i][6:5], ev[i][4], ev[i][3], ev[i][2:0]);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_order();
        test_simultaneous();
        test_withdraw();
        test_timeout();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
